// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, FSM states, flag bundle.
// Also holds the operand-conditioning rules used by the serial adder.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

  // Subtracting ops add the inverted second operand.
  function automatic logic op_inv_b(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

  function automatic logic op_cin(
    input logic [1:0] op,
    input logic       carry_in
  );
    logic c;
    unique case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      default: c = carry_in;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit ripple adder built from full-adder cells.
// Shared by every cycle of a serial add/subtract.
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  logic [CHUNK:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) |
                      (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[CHUNK];

endmodule

// File: rtl/addsub_serial.sv
// Chunk-serial add/subtract with carry chaining and NZCV-style flags.
// One CHUNK-bit adder is reused for NCHUNK cycles per operation.
module addsub_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("addsub_serial: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] res_q, res_d;
  flags_t           flg_q, flg_d;

  logic [CHUNK-1:0] ch_a, ch_b, ch_sum;
  logic             ch_cout;
  logic             load;
  logic             last;
  logic             msb_cin;

  assign in_ready  = (state_q == ST_IDLE) ||
                     ((state_q == ST_DONE) && out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign load      = in_valid && in_ready;
  assign last      = (cnt_q == CW'(NCHUNK - 1));

  always_comb begin
    ch_a = '0;
    ch_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt_q == CW'(i)) begin
        ch_a = a_q[i*CHUNK +: CHUNK];
        ch_b = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  addsub_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a_i   (ch_a),
    .b_i   (ch_b),
    .cin_i (cy_q),
    .sum_o (ch_sum),
    .cout_o(ch_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cy_d    = cy_q;
    res_d   = res_q;
    flg_d   = flg_q;
    msb_cin = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        for (int i = 0; i < NCHUNK; i++) begin
          if (cnt_q == CW'(i)) res_d[i*CHUNK +: CHUNK] = ch_sum;
        end
        cy_d  = ch_cout;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          // Carry into the MSB recovered from the sum bit itself.
          msb_cin = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ res_d[WIDTH-1];
          flg_d.carry    = ch_cout;
          flg_d.overflow = msb_cin ^ ch_cout;
          flg_d.zero     = (res_d == '0);
          flg_d.negative = res_d[WIDTH-1];
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = in_valid ? ST_BUSY : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      a_d   = a;
      b_d   = op_inv_b(op) ? ~b : b;
      cy_d  = op_cin(op, carry_in);
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign result   = res_q;
  assign carry    = flg_q.carry;
  assign overflow = flg_q.overflow;
  assign zero     = flg_q.zero;
  assign negative = flg_q.negative;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial (WIDTH 16, CHUNK 4): directed cases,
// backpressure, mid-op reset and randomized ops against an arithmetic model.
module tb_addsub_serial;

  localparam int W = 16;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [1:0]   op;
  logic         carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry, overflow, zero, negative;

  int errs = 0;
  int checks = 0;

  addsub_serial #(.WIDTH(16), .CHUNK(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .carry_in (carry_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative)
  );

  always #5 clk = ~clk;

  task automatic model(
    input  logic [1:0]   o,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] r,
    output logic         c,
    output logic         v,
    output logic         z,
    output logic         n
  );
    longint ux, uy, sx, sy, k, us, ss;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    k  = (o == 2'b00) ? 0 : (o == 2'b01) ? 1 : longint'(ci);
    if (o[0] == 1'b0) begin
      us = ux + uy + k;
      ss = sx + sy + k;
      c  = (us >= 65536);
    end else begin
      us = ux - uy - (1 - k);
      ss = sx - sy - (1 - k);
      c  = (us >= 0);
    end
    r = us[W-1:0];
    v = (ss > 32767) || (ss < -32768);
    z = (r == '0);
    n = r[W-1];
  endtask

  task automatic run_op(
    input  logic [1:0]   o,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output int           lat,
    output logic [W-1:0] r,
    output logic [3:0]   f
  );
    int g;
    @(negedge clk);
    op = o; a = x; b = y; carry_in = ci; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    op = 2'($urandom); carry_in = 1'($urandom);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    r = result;
    f = {carry, overflow, zero, negative};
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0; carry_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_hs got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
    end
    checks++;
    if (result !== '0 || {carry, overflow, zero, negative} !== 4'b0) begin
      errs++;
      $display("FAIL reset_state got res=%h f=%b exp 0000 0000", result,
               {carry, overflow, zero, negative});
    end
  endtask

  task automatic test_directed();
    logic [1:0]   t_op [8] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    logic [W-1:0] t_a  [8] = '{16'h7FFF, 16'h0005, 16'h0000, 16'h8000,
                               16'hFFFF, 16'h0000, 16'h0001, 16'h0003};
    logic [W-1:0] t_b  [8] = '{16'h0001, 16'h0005, 16'h0001, 16'h0001,
                               16'h0000, 16'h0000, 16'h0001, 16'h0001};
    logic         t_ci [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] t_r  [8] = '{16'h8000, 16'h0000, 16'hFFFF, 16'h7FFF,
                               16'h0000, 16'hFFFF, 16'h0002, 16'h0002};
    // carry, overflow, zero, negative
    logic [3:0]   t_f  [8] = '{4'b0101, 4'b1010, 4'b0001, 4'b1100,
                               4'b1010, 4'b0001, 4'b0000, 4'b1000};
    int lat;
    logic [W-1:0] r;
    logic [3:0] f;
    for (int i = 0; i < 8; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], t_ci[i], lat, r, f);
      checks++;
      if (lat != LAT) begin
        errs++;
        $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, LAT);
      end
      checks++;
      if (r !== t_r[i]) begin
        errs++;
        $display("FAIL dir%0d_result got %h exp %h", i, r, t_r[i]);
      end
      checks++;
      if (f !== t_f[i]) begin
        errs++;
        $display("FAIL dir%0d_flags got %b exp %b", i, f, t_f[i]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] r;
    logic [3:0] f;
    run_op(2'b00, 16'h00F0, 16'h0F00, 1'b0, lat, r, f);
    checks++;
    if (r !== 16'h0FF0 || f !== 4'b0000) begin
      errs++;
      $display("FAIL bp_first got %h/%b exp 0ff0/0000", r, f);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'h0FF0 ||
          {carry, overflow, zero, negative} !== 4'b0000) begin
        errs++;
        $display("FAIL bp_hold%0d got ov=%b ir=%b res=%h exp 1 0 0ff0", k,
                 out_valid, in_ready, result);
      end
    end
    @(negedge clk);
    op = 2'b00; a = 16'h0001; b = 16'h0001; carry_in = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL bp_accept_ready got %b exp 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errs++;
      $display("FAIL bp_drop got ov=%b ir=%b exp 0 0", out_valid, in_ready);
    end
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != LAT || result !== 16'h0002) begin
      errs++;
      $display("FAIL bp_second got lat=%0d res=%h exp %0d 0002", lat, result, LAT);
    end
    consume();
  endtask

  task automatic test_reset_busy();
    int lat;
    logic [W-1:0] r;
    logic [3:0] f;
    @(negedge clk);
    op = 2'b00; a = 16'hFFFF; b = 16'hFFFF; carry_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 ||
        {carry, overflow, zero, negative} !== 4'b0) begin
      errs++;
      $display("FAIL rstbusy got ov=%b ir=%b res=%h exp 0 1 0000",
               out_valid, in_ready, result);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(2'b00, 16'h1234, 16'h1111, 1'b0, lat, r, f);
    checks++;
    if (lat != LAT || r !== 16'h2345 || f !== 4'b0000) begin
      errs++;
      $display("FAIL rstbusy_next got lat=%0d res=%h f=%b exp %0d 2345 0000",
               lat, r, f, LAT);
    end
    consume();
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] r, er;
    logic [3:0] f;
    logic ec, ev, ez, en;
    logic [1:0] o;
    logic [W-1:0] x, y;
    logic ci;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom); ci = 1'($urandom);
      x = 16'($urandom); y = 16'($urandom);
      if (i % 8 == 0) y = x;
      model(o, x, y, ci, er, ec, ev, ez, en);
      run_op(o, x, y, ci, lat, r, f);
      checks++;
      if (lat != LAT || r !== er || f !== {ec, ev, ez, en}) begin
        errs++;
        $display("FAIL rand%0d op=%0d %h,%h,%b got lat=%0d %h/%b exp %0d %h/%b",
                 i, o, x, y, ci, lat, r, f, LAT, er, {ec, ev, ez, en});
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
